// File: rtl/draw_triangle.sv
// Triangle outline sequencer.
// Latches three vertices and a colour on start, range-checks them, then
// issues the three outline edges one at a time to a downstream line drawer
// through a four-phase ln_start/ln_done handshake.
module draw_triangle #(
  parameter int unsigned XMAX = 159,
  parameter int unsigned YMAX = 119
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [6:0] y2,
  input  logic [2:0] colour,
  output logic       done,
  output logic       err,
  output logic       ln_start,
  output logic [7:0] ln_x0,
  output logic [7:0] ln_x1,
  output logic [6:0] ln_y0,
  output logic [6:0] ln_y1,
  output logic [2:0] ln_colour,
  input  logic       ln_done
);

  localparam logic [7:0] XLim = 8'(XMAX);
  localparam logic [6:0] YLim = 7'(YMAX);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StEdgeReq,
    StEdgeRel,
    StFinish
  } state_e;

  state_e state_q, state_d;

  // Latched triangle description.
  logic [7:0] vx0_q, vx1_q, vx2_q;
  logic [6:0] vy0_q, vy1_q, vy2_q;
  logic [2:0] col_q;
  logic       capture;

  logic [1:0] edge_cnt_q, edge_cnt_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ln_start_q, ln_start_d;

  // Line endpoint registers, reloaded only when entering StEdgeReq.
  logic [7:0] ln_x0_q, ln_x1_q;
  logic [6:0] ln_y0_q, ln_y1_q;
  logic [2:0] ln_colour_q;
  logic       load_ln;

  // Endpoints of the edge about to be requested.
  logic [7:0] sel_xa, sel_xb;
  logic [6:0] sel_ya, sel_yb;

  logic range_bad;

  assign capture = (state_q == StIdle) && start;

  // Inclusive bounds: XMAX/YMAX themselves are legal.
  assign range_bad = (vx0_q > XLim) || (vx1_q > XLim) || (vx2_q > XLim) ||
                     (vy0_q > YLim) || (vy1_q > YLim) || (vy2_q > YLim);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Vertex and colour capture on the accepting edge in StIdle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx0_q <= '0;
      vx1_q <= '0;
      vx2_q <= '0;
      vy0_q <= '0;
      vy1_q <= '0;
      vy2_q <= '0;
      col_q <= '0;
    end else if (capture) begin
      vx0_q <= x0;
      vx1_q <= x1;
      vx2_q <= x2;
      vy0_q <= y0;
      vy1_q <= y1;
      vy2_q <= y2;
      col_q <= colour;
    end
  end

  // Handshake, status and edge-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ln_start_q <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ln_start_q <= ln_start_d;
    end
  end

  // Edge endpoint selection, indexed by the edge being entered.
  always_comb begin
    sel_xa = vx2_q;
    sel_ya = vy2_q;
    sel_xb = vx0_q;
    sel_yb = vy0_q;
    unique case (edge_cnt_d)
      2'd0: begin
        sel_xa = vx0_q;
        sel_ya = vy0_q;
        sel_xb = vx1_q;
        sel_yb = vy1_q;
      end
      2'd1: begin
        sel_xa = vx1_q;
        sel_ya = vy1_q;
        sel_xb = vx2_q;
        sel_yb = vy2_q;
      end
      default: begin
        sel_xa = vx2_q;
        sel_ya = vy2_q;
        sel_xb = vx0_q;
        sel_yb = vy0_q;
      end
    endcase
  end

  // Line endpoint registers; held stable for the whole handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ln_x0_q     <= '0;
      ln_y0_q     <= '0;
      ln_x1_q     <= '0;
      ln_y1_q     <= '0;
      ln_colour_q <= '0;
    end else if (load_ln) begin
      ln_x0_q     <= sel_xa;
      ln_y0_q     <= sel_ya;
      ln_x1_q     <= sel_xb;
      ln_y1_q     <= sel_yb;
      ln_colour_q <= col_q;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    ln_start_d = 1'b0;
    load_ln    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCheck;
        end
      end

      StCheck: begin
        if (range_bad) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StFinish;
        end else begin
          edge_cnt_d = 2'd0;
          load_ln    = 1'b1;
          state_d    = StEdgeReq;
        end
      end

      StEdgeReq: begin
        // ln_done only counts once ln_start is visible downstream, so a
        // stale ln_done from the previous line cannot skip the request.
        if (ln_start_q && ln_done) begin
          state_d = StEdgeRel;
        end else begin
          ln_start_d = 1'b1;
        end
      end

      StEdgeRel: begin
        if (!ln_done) begin
          if (edge_cnt_q == 2'd2) begin
            done_d  = 1'b1;
            state_d = StFinish;
          end else begin
            edge_cnt_d = edge_cnt_q + 2'd1;
            load_ln    = 1'b1;
            state_d    = StEdgeReq;
          end
        end
      end

      StFinish: begin
        // Leaving only on start=0 prevents re-triggering from a held start.
        if (!start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign done      = done_q;
  assign err       = err_q;
  assign ln_start  = ln_start_q;
  assign ln_x0     = ln_x0_q;
  assign ln_y0     = ln_y0_q;
  assign ln_x1     = ln_x1_q;
  assign ln_y1     = ln_y1_q;
  assign ln_colour = ln_colour_q;

endmodule

// File: tb/tb_draw_triangle.sv
// Directed bench for draw_triangle with a variable-latency line drawer model.
module tb_draw_triangle;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x0, x1, x2;
  logic [6:0] y0, y1, y2;
  logic [2:0] colour;
  logic       done, err, ln_start;
  logic [7:0] ln_x0, ln_x1;
  logic [6:0] ln_y0, ln_y1;
  logic [2:0] ln_colour;
  logic       ln_done;

  int checks = 0;
  int errors = 0;

  draw_triangle #(
    .XMAX(159),
    .YMAX(119)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x0       (x0),
    .x1       (x1),
    .x2       (x2),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .colour   (colour),
    .done     (done),
    .err      (err),
    .ln_start (ln_start),
    .ln_x0    (ln_x0),
    .ln_x1    (ln_x1),
    .ln_y0    (ln_y0),
    .ln_y1    (ln_y1),
    .ln_colour(ln_colour),
    .ln_done  (ln_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line drawer model: finishes 3-20 cycles after ln_start, then waits for release.
  logic busy;
  int   dly;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      dly     <= 0;
      ln_done <= 1'b0;
    end else if (!busy && !ln_done && ln_start) begin
      busy <= 1'b1;
      dly  <= int'($urandom_range(3, 20));
    end else if (busy) begin
      if (dly <= 1) begin
        busy    <= 1'b0;
        ln_done <= 1'b1;
      end else begin
        dly <= dly - 1;
      end
    end else if (ln_done && !ln_start) begin
      ln_done <= 1'b0;
    end
  end

  // Request monitor: logs each request and counts endpoint changes mid-handshake.
  logic [32:0] req_q[$];
  logic [32:0] cur_req;
  logic        start_prev;
  int          req_cnt  = 0;
  int          unstable = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev <= 1'b0;
    end else begin
      start_prev <= ln_start;
      if (ln_start && !start_prev) begin
        req_q.push_back({ln_x0, ln_y0, ln_x1, ln_y1, ln_colour});
        cur_req <= {ln_x0, ln_y0, ln_x1, ln_y1, ln_colour};
        req_cnt <= req_cnt + 1;
      end else if ((ln_start || ln_done) &&
                   ({ln_x0, ln_y0, ln_x1, ln_y1, ln_colour} != cur_req)) begin
        unstable <= unstable + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] pk(input logic [7:0] ax, input logic [6:0] ay,
                                     input logic [7:0] bx, input logic [6:0] by,
                                     input logic [2:0] c);
    return {ax, ay, bx, by, c};
  endfunction

  task automatic set_tri(input logic [7:0] a0, input logic [6:0] b0, input logic [7:0] a1,
                         input logic [6:0] b1, input logic [7:0] a2, input logic [6:0] b2,
                         input logic [2:0] c);
    x0 = a0; y0 = b0; x1 = a1; y1 = b1; x2 = a2; y2 = b2; colour = c;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic wait_reqs(input string tag, input int target);
    int n = 0;
    while (req_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, (req_cnt >= target), 1'b1);
  endtask

  task automatic check_req(input string tag, input int idx, input logic [32:0] exp);
    logic [32:0] act;
    act = (idx < req_q.size()) ? req_q[idx] : '1;
    check(tag, act, exp);
  endtask

  // Checks the three requests of one triangle starting at queue index base.
  task automatic check_tri(input string tag, input int base, input logic [7:0] a0,
                           input logic [6:0] b0, input logic [7:0] a1, input logic [6:0] b1,
                           input logic [7:0] a2, input logic [6:0] b2, input logic [2:0] c);
    check_req({tag, "_e0"}, base,     pk(a0, b0, a1, b1, c));
    check_req({tag, "_e1"}, base + 1, pk(a1, b1, a2, b2, c));
    check_req({tag, "_e2"}, base + 2, pk(a2, b2, a0, b0, c));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_tri(8'd0, 7'd0, 8'd0, 7'd0, 8'd0, 7'd0, 3'd0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ln_start", ln_start, 1'b0);
    check("rst_ln_pts", {ln_x0, ln_y0, ln_x1, ln_y1, ln_colour}, 33'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic triangle with latency check
    req_q.delete();
    set_tri(8'd59, 7'd20, 8'd50, 7'd25, 8'd50, 7'd20, 3'd2);
    start = 1'b1;
    @(posedge clk); #1;
    check("t1_lat_n", ln_start, 1'b0);
    @(posedge clk); #1;
    check("t1_lat_n1", ln_start, 1'b0);
    check("t1_done_early", done, 1'b0);
    @(posedge clk); #1;
    check("t1_lat_n2", ln_start, 1'b1);
    wait_done("t1_done");
    check("t1_err", err, 1'b0);
    check("t1_nreq", req_q.size(), 3);
    check_tri("t1", 0, 8'd59, 7'd20, 8'd50, 7'd25, 8'd50, 7'd20, 3'd2);
    repeat (5) @(negedge clk);
    check("t1_done_held", done, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check("t1_done_clr", done, 1'b0);

    // Out-of-range x1
    req_q.delete();
    set_tri(8'd10, 7'd10, 8'd160, 7'd10, 8'd20, 7'd20, 3'd1);
    start = 1'b1;
    @(posedge clk); #1;
    check("t2_done_n", done, 1'b0);
    @(posedge clk); #1;
    check("t2_done_n1", done, 1'b1);
    check("t2_err_n1", err, 1'b1);
    repeat (6) @(negedge clk);
    check("t2_no_req", req_q.size(), 0);
    check("t2_ln_start", ln_start, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check("t2_done_clr", done, 1'b0);
    check("t2_err_clr", err, 1'b0);
    @(negedge clk);

    // Inclusive boundary
    req_q.delete();
    set_tri(8'd159, 7'd119, 8'd0, 7'd0, 8'd159, 7'd0, 3'd7);
    start = 1'b1;
    wait_done("t3_done");
    check("t3_err", err, 1'b0);
    check("t3_nreq", req_q.size(), 3);
    check_tri("t3", 0, 8'd159, 7'd119, 8'd0, 7'd0, 8'd159, 7'd0, 3'd7);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Fully degenerate triangle
    req_q.delete();
    set_tri(8'd10, 7'd10, 8'd10, 7'd10, 8'd10, 7'd10, 3'd5);
    start = 1'b1;
    wait_done("t4_done");
    check("t4_err", err, 1'b0);
    check("t4_nreq", req_q.size(), 3);
    check_tri("t4", 0, 8'd10, 7'd10, 8'd10, 7'd10, 8'd10, 7'd10, 3'd5);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during edge 1
    req_q.delete();
    set_tri(8'd30, 7'd40, 8'd70, 7'd5, 8'd100, 7'd90, 3'd3);
    start = 1'b1;
    wait_reqs("t5_reach_e1", req_cnt + 2);
    rst = 1'b1;
    #1;
    check("t5_rst_ln_start", ln_start, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_ln_x0", ln_x0, 8'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req_q.delete();
    repeat (4) @(negedge clk);
    check("t5_idle_no_req", req_q.size(), 0);
    check("t5_idle_done", done, 1'b0);
    start = 1'b1;
    wait_done("t5_done");
    check("t5_nreq", req_q.size(), 3);
    check_tri("t5", 0, 8'd30, 7'd40, 8'd70, 7'd5, 8'd100, 7'd90, 3'd3);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Inputs changed while busy; start held through FINISH
    req_q.delete();
    set_tri(8'd1, 7'd2, 8'd3, 7'd4, 8'd5, 7'd6, 3'd4);
    start = 1'b1;
    wait_reqs("t6_first", req_cnt + 1);
    set_tri(8'd90, 7'd80, 8'd91, 7'd81, 8'd92, 7'd82, 3'd6);
    wait_done("t6_done");
    check("t6_nreq", req_q.size(), 3);
    check_tri("t6", 0, 8'd1, 7'd2, 8'd3, 7'd4, 8'd5, 7'd6, 3'd4);
    repeat (10) @(negedge clk);
    check("t6_held_done", done, 1'b1);
    check("t6_held_noreq", req_q.size(), 3);
    start = 1'b0;
    @(negedge clk);
    check("t6_done_clr", done, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_low_noreq", req_q.size(), 3);
    start = 1'b1;
    wait_done("t6b_done");
    check("t6b_nreq", req_q.size(), 6);
    check_tri("t6b", 3, 8'd90, 7'd80, 8'd91, 7'd81, 8'd92, 7'd82, 3'd6);
    start = 1'b0;
    repeat (2) @(negedge clk);

    check("ln_stable", unstable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_triangle.md
DRAW_TRIANGLE -- requirements
Module: draw_triangle

Interface
REQ-001 The block SHALL have parameter XMAX, default 159, meaning the largest legal x coordinate.
REQ-002 The block SHALL have parameter YMAX, default 119, meaning the largest legal y coordinate.
REQ-003 Ports SHALL be as follows:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to draw one triangle.
- x0, x1, x2  input  8 each  vertex x coordinates.
- y0, y1, y2  input  7 each  vertex y coordinates.
- colour  input  3  triangle colour.
- done  output  1  triangle finished.
- err  output  1  vertex out of range; valid only while done=1.
- ln_start  output  1  start request to the downstream line drawer.
- ln_x0, ln_x1  output  8 each  line endpoint x coordinates.
- ln_y0, ln_y1  output  7 each  line endpoint y coordinates.
- ln_colour  output  3  line colour.
- ln_done  input  1  line-drawer completion.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 The FSM SHALL have exactly these states: IDLE, CHECK, EDGE_REQ, EDGE_REL, FINISH.
REQ-006 IDLE SHALL behave as follows:
- On the edge where start=1 is sampled, the block latches x0..x2, y0..y2 and colour, then moves to CHECK.
- Input changes after that latch SHALL have no effect until the next IDLE.
REQ-007 CHECK SHALL last exactly 1 cycle:
- If any latched x > XMAX or any latched y > YMAX, the block sets err=1 and goes to FINISH, issuing no line.
- Otherwise it sets the 2-bit edge counter to 0 and goes to EDGE_REQ.
REQ-008 Edge mapping SHALL be as follows:
- Edge 0: (x0,y0)->(x1,y1).
- Edge 1: (x1,y1)->(x2,y2).
- Edge 2: (x2,y2)->(x0,y0).
- ln_x0/ln_y0 SHALL carry the first point, ln_x1/ln_y1 the second, and ln_colour the latched colour.
REQ-009 The ln_* endpoint and colour outputs SHALL be updated on the edge entering EDGE_REQ and SHALL then hold stable through EDGE_REL.
REQ-010 In EDGE_REQ, ln_start SHALL be 1 and held until ln_done=1 is sampled, then the block moves to EDGE_REL.
REQ-011 In EDGE_REL, ln_start SHALL be 0 and held until ln_done=0 is sampled.
- If edge counter = 2, the block goes to FINISH.
- Otherwise it increments the counter and goes to EDGE_REQ.
REQ-012 Latency: if start is sampled at edge N, ln_start SHALL first be 1 after edge N+2.
REQ-013 done SHALL become 1 on the edge that leaves EDGE_REL after edge 2, or on the edge that leaves CHECK with err.
REQ-014 In FINISH, done=1 SHALL be held until start=0 is sampled; then done=0, err=0 and the state returns to IDLE on that edge.
REQ-015 Deasserting start while in CHECK/EDGE_REQ/EDGE_REL SHALL be ignored, and the triangle completes.
REQ-016 If start is still 1 when done falls, no new triangle SHALL start until start has been sampled 0 in FINISH, so the block SHALL never re-trigger from a held start.
REQ-017 Degenerate edges (equal endpoints) and degenerate triangles SHALL still issue all three line requests unchanged.
REQ-018 If ln_done=1 is already asserted on entry to EDGE_REQ, the block SHALL still assert ln_start for at least 1 cycle before moving to EDGE_REL.
REQ-019 Range checks SHALL be inclusive: x=XMAX and y=YMAX are legal; x=XMAX+1 is illegal.

Reset
REQ-020 While rst=1, regardless of clk, the block SHALL force:
- state=IDLE;
- done=0, err=0, ln_start=0;
- ln_x0=ln_x1=0, ln_y0=ln_y1=0, ln_colour=0;
- edge counter=0.
REQ-021 Reset mid-operation SHALL drop ln_start immediately, and after rst falls the block SHALL wait in IDLE for a fresh start.

Verification
REQ-022 The bench SHALL pair the block with a drawline model that completes each line after a variable delay of 3-20 cycles, and SHALL check the following directed scenarios:
- Vertices (59,20),(50,25),(50,20), colour=2, start held → three requests in order (59,20)->(50,25), (50,25)->(50,20), (50,20)->(59,20), each with ln_colour=2 → done=1, err=0 → drop start → done=0.
- Vertex x1=160 → no ln_start pulse, done=1 with err=1 two cycles after start; err clears when start drops.
- Boundary vertices (159,119),(0,0),(159,0) → err=0 and three lines issued.
- All vertices equal (10,10) → three requests each with endpoints (10,10)->(10,10) → done=1.
- rst=1 during edge 1 → ln_start=0 and done=0 immediately → next start draws the full triangle from edge 0.
- Vertex inputs changed while busy, and start held 1 through FINISH → endpoints match the originally latched values → no second triangle until start is cycled low/high.
